normalizer_seq: RTL and testbench
=================================

# normalizer_seq

Iterative left-normalizer for the execute stage, and the inverse of the barrel shifter: given a 32-bit operand it recovers the left-shift amount that normalizes the value and returns the normalized word. It runs multi-cycle behind a start/busy/done handshake and serves count-leading-zeros/sign style instructions and the soft-float path. It shifts one or four bits per cycle, so the datapath cost is small.

## Interface
- `WIDTH`, default 32: operand width. Only 32 is supported.
- `clock`, in, 1: the single clock; all state changes on its rising edge.
- `reset_n`, in, 1: synchronous, active-low reset.
- `start`, in, 1: request a normalization. Sampled only in IDLE.
- `mode`, in, 1:
  - 0 = unsigned: shift until bit31 = 1.
  - 1 = signed: shift until bit31 != bit30.
- `value_in`, in, 32: operand, captured on the start edge.
- `result`, out, 32: normalized value.
- `count`, out, 6: number of bit positions shifted, 0..32.
- `zero`, out, 1: operand carried no significant bits.
- `busy`, out, 1: high in SHIFT and DONE.
- `done`, out, 1: one-cycle pulse; `result`, `count` and `zero` are valid from this cycle onward.

## Operation
- States and transitions:
  - IDLE, with `start` = 1: capture `value_in` and `mode`, clear `count`, go to SHIFT.
  - IDLE, with `start` = 0: stay in IDLE.
  - SHIFT: evaluate the termination check each cycle.
  - SHIFT, terminating: go to DONE.
  - SHIFT, not terminating: shift left (zero fill), add the step to `count`.
  - DONE: pulse `done`, return to IDLE.
- Termination conditions:
  - Unsigned: value[31] = 1.
  - Signed: value[31] != value[30].
- Zero shortcut, applied on the first SHIFT cycle:
  - Unsigned, value == 0: `count` = 32, `result` = 0, `zero` = 1, go to DONE.
  - Signed, value == 0x00000000 or 0xFFFFFFFF: `count` = 31, `result` = value << 31 (0x00000000 or 0x80000000), `zero` = 1.
- `zero` = 0 in every other case.
- `count` is 6 bits; it never exceeds 32, and no wrap is possible.
- `start` is ignored while `busy` is high. No queueing: the request is dropped.
- `result`, `count` and `zero` hold their values from `done` until the next accepted start.
- Reset is synchronous. When `reset_n` is sampled low, in any state including mid-SHIFT:
  - the state returns to IDLE;
  - `result`, `count`, `zero`, `busy` and `done` all go to 0;
  - any in-flight operation is abandoned.

## Timing
- Define n as the number of shift steps performed.
- Start sampled at edge E0. `busy` rises after E0.
- Steps occur at edges E1..En. The terminating check is made at edge E(n+1).
- `done` is high during the cycle after E(n+1). `busy` falls after E(n+2).
- Latency from start to `done` is n+1 cycles. Throughput is one operation per n+3 cycles, because IDLE is re-entered before a new start is accepted.
- One-bit mode: n = c, where c is the final `count`. Worst case, unsigned 1: n = 31, latency 32 cycles.
- Zero shortcut: n = 0, latency 1 cycle.
- Reset values: every output is 0.

## Configuration
- `NORM_STEP4_EN` defined: in SHIFT, take a step of 4 when the remaining shift is at least 4. This holds when:
  - unsigned: bits[31:28] are all 0;
  - signed: bits[31:27] are all equal.
  
  Otherwise take a step of 1. This gives n = floor(c/4) + (c mod 4).
- `NORM_STEP4_EN` undefined: the step is always 1.
- Final `result`, `count` and `zero` are identical in both builds. Only latency differs.

## Structure
- `normalizer_pkg` holds:
  - the state enum {IDLE, SHIFT, DONE};
  - `MODE_UNSIGNED` = 0 and `MODE_SIGNED` = 1;
  - the `COUNT_W` = 6 constant;
  - the zero-count constants 32 and 31.
- One combinational sub-module, `norm_detect`, takes the value, mode and step option and returns `terminate`, `is_zero` and `step` (1 or 4). The FSM and registers stay in `normalizer_seq`.

## Test plan
- Unsigned 0x00010000:
  - `count` = 15, `result` = 0x80000000, `zero` = 0.
  - Latency 16 cycles (1-bit build) or 7 cycles (step-4 build).
- Signed 0xFFFF8000: `count` = 16, `result` = 0x80000000. Signed 0x00000001: `count` = 30, `result` = 0x40000000.
- Zero cases:
  - Unsigned 0x00000000: `count` = 32, `zero` = 1, `done` 1 cycle after start.
  - Signed 0xFFFFFFFF: `count` = 31, `result` = 0x80000000, `zero` = 1.
- Already normalized: unsigned 0x80000001 gives `count` = 0, `result` unchanged, latency 1 cycle.
- Start held high throughout an operation:
  - exactly one `done` per accepted start;
  - the second operation begins only after `busy` falls;
  - results hold between operations.
- `reset_n` low mid-SHIFT on 0x00000001: next cycle all outputs are 0 and the state is IDLE. A new start then completes normally.

Source files
------------

// File: rtl/normalizer_pkg.sv
// Shared types and constants for the iterative left-normalizer.
package normalizer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic MODE_UNSIGNED = 1'b0;
  localparam logic MODE_SIGNED   = 1'b1;

  localparam int COUNT_W = 6;

  // Counts reported when the operand has no significant bits at all.
  localparam logic [COUNT_W-1:0] ZERO_CNT_UNSIGNED = 6'd32;
  localparam logic [COUNT_W-1:0] ZERO_CNT_SIGNED   = 6'd31;

  localparam logic [2:0] STEP_ONE  = 3'd1;
  localparam logic [2:0] STEP_FOUR = 3'd4;

endpackage

// File: rtl/norm_detect.sv
// Combinational termination / zero / step-size decode for the normalizer.
module norm_detect
  import normalizer_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] value_i,
  input  logic             mode_i,
  input  logic             step4_en_i,
  output logic             terminate_o,
  output logic             is_zero_o,
  output logic [2:0]       step_o
);

  logic room4;

  always_comb begin
    terminate_o = 1'b0;
    is_zero_o   = 1'b0;
    room4       = 1'b0;
    if (mode_i == MODE_UNSIGNED) begin
      terminate_o = value_i[WIDTH-1];
      is_zero_o   = (value_i == '0);
      room4       = (value_i[WIDTH-1 -: 4] == 4'b0000);
    end else begin
      terminate_o = value_i[WIDTH-1] ^ value_i[WIDTH-2];
      is_zero_o   = (value_i == '0) || (value_i == '1);
      // Five equal top bits: sign plus at least four redundant copies.
      room4       = (value_i[WIDTH-1 -: 5] == 5'b00000) ||
                    (value_i[WIDTH-1 -: 5] == 5'b11111);
    end
    step_o = (step4_en_i && room4) ? STEP_FOUR : STEP_ONE;
  end

endmodule

// File: rtl/normalizer_seq.sv
// Iterative left-normalizer: returns the normalizing left-shift count and shifted word.
// Define NORM_STEP4_EN to shift four bits per cycle while four remain; results are unchanged.
module normalizer_seq
  import normalizer_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  input  logic               mode,
  input  logic [WIDTH-1:0]   value_in,
  output logic [WIDTH-1:0]   result,
  output logic [COUNT_W-1:0] count,
  output logic               zero,
  output logic               busy,
  output logic               done
);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   value_q, value_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               mode_q, mode_d;
  logic               zero_q, zero_d;
  logic               terminate, is_zero, step4_en;
  logic [2:0]         step;

`ifdef NORM_STEP4_EN
  assign step4_en = 1'b1;
`else
  assign step4_en = 1'b0;
`endif

  norm_detect #(.WIDTH(WIDTH)) u_detect (
    .value_i     (value_q),
    .mode_i      (mode_q),
    .step4_en_i  (step4_en),
    .terminate_o (terminate),
    .is_zero_o   (is_zero),
    .step_o      (step)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (is_zero || terminate) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != IDLE);
    done = (state_q == DONE);
  end

  always_comb begin
    value_d = value_q;
    count_d = count_q;
    mode_d  = mode_q;
    zero_d  = zero_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          value_d = value_in;
          mode_d  = mode;
          count_d = '0;
          zero_d  = 1'b0;
        end
      end
      SHIFT: begin
        if (is_zero) begin
          // Unsigned zero stays zero; signed all-ones leaves only the sign bit.
          zero_d  = 1'b1;
          count_d = (mode_q == MODE_SIGNED) ? ZERO_CNT_SIGNED : ZERO_CNT_UNSIGNED;
          value_d = value_q << (WIDTH-1);
        end else if (!terminate) begin
          value_d = value_q << step;
          count_d = count_q + COUNT_W'(step);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      value_q <= '0;
      count_q <= '0;
      mode_q  <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      value_q <= value_d;
      count_q <= count_d;
      mode_q  <= mode_d;
      zero_q  <= zero_d;
    end
  end

  assign result = value_q;
  assign count  = count_q;
  assign zero   = zero_q;

endmodule

// File: tb/tb_normalizer_seq.sv
// Scoreboard bench for normalizer_seq: a leading-bit-count reference model predicts each operation.
module tb_normalizer_seq;

  logic        clock;
  logic        reset_n;
  logic        start;
  logic        mode;
  logic [31:0] value_in;
  logic [31:0] result;
  logic [5:0]  count;
  logic        zero;
  logic        busy;
  logic        done;

  normalizer_seq #(.WIDTH(32)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .start    (start),
    .mode     (mode),
    .value_in (value_in),
    .result   (result),
    .count    (count),
    .zero     (zero),
    .busy     (busy),
    .done     (done)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    logic [31:0] res;
    logic [5:0]  cnt;
    logic        zr;
    int          lat;
    int          start_cyc;
  } exp_t;

  exp_t        sb[$];
  exp_t        me;
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
  logic        hold_valid = 1'b0;
  logic [31:0] hold_res;
  logic [5:0]  hold_cnt;
  logic        hold_zr;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: count redundant leading bits directly, then shift by that amount.
  function automatic exp_t model(input logic m, input logic [31:0] v);
    exp_t e;
    int   c;
    int   n;
    e.zr = 1'b0;
    c = 0;
    if (!m) begin
      if (v == 32'h0) begin
        c = 32; e.zr = 1'b1; e.res = 32'h0;
      end else begin
        while (v[31-c] == 1'b0) c++;
        e.res = v << c;
      end
    end else begin
      if (v == 32'h0 || v == 32'hFFFF_FFFF) begin
        c = 31; e.zr = 1'b1; e.res = v << 31;
      end else begin
        while (v[30-c] == v[31]) c++;
        e.res = v << c;
      end
    end
    e.cnt = 6'(c);
    if (e.zr) n = 0;
    else begin
`ifdef NORM_STEP4_EN
      n = c / 4 + c % 4;
`else
      n = c;
`endif
    end
    e.lat = n + 1;
    e.start_cyc = 0;
    return e;
  endfunction

  always @(negedge clock) begin
    if (reset_n && done) begin
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_done: got done=1 expected no pending operation (t=%0t)", $time);
      end else begin
        me = sb.pop_front();
        check("result", result, me.res);
        check("count", {26'h0, count}, {26'h0, me.cnt});
        check("zero", {31'h0, zero}, {31'h0, me.zr});
        check("latency", cyc - me.start_cyc, me.lat);
        hold_res = me.res; hold_cnt = me.cnt; hold_zr = me.zr;
        hold_valid = 1'b1;
      end
    end else if (reset_n && hold_valid && !busy) begin
      check("hold_result", result, hold_res);
      check("hold_count", {26'h0, count}, {26'h0, hold_cnt});
      check("hold_zero", {31'h0, zero}, {31'h0, hold_zr});
    end
  end

  task automatic wait_idle();
    int g = 0;
    while (busy && g < 200) begin
      @(negedge clock);
      g++;
    end
    if (busy) begin
      total++; bad++;
      $display("FAIL idle_timeout: got busy=1 expected busy=0 within 200 cycles");
    end
  endtask

  task automatic issue(input logic m, input logic [31:0] v);
    exp_t e;
    wait_idle();
    start = 1'b1; mode = m; value_in = v;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0; mode = 1'($urandom); value_in = $urandom;
    e = model(m, v);
    e.start_cyc = cyc;
    sb.push_back(e);
  endtask

  task automatic held_start(input logic m1, input logic [31:0] v1,
                            input logic m2, input logic [31:0] v2);
    exp_t e;
    wait_idle();
    start = 1'b1; mode = m1; value_in = v1;
    @(posedge clock);
    @(negedge clock);
    e = model(m1, v1);
    e.start_cyc = cyc;
    sb.push_back(e);
    mode = m2; value_in = v2;
    wait_idle();
    @(posedge clock);
    @(negedge clock);
    e = model(m2, v2);
    e.start_cyc = cyc;
    sb.push_back(e);
    start = 1'b0;
  endtask

  initial begin
    int g;
    logic        m;
    logic [31:0] v;
    int          sel;

    reset_n = 1'b0; start = 1'b0; mode = 1'b0; value_in = 32'h0;
    repeat (3) @(negedge clock);
    check("rst_result", result, 32'h0);
    check("rst_count", {26'h0, count}, 32'h0);
    check("rst_zero", {31'h0, zero}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_done", {31'h0, done}, 32'h0);
    reset_n = 1'b1;

    issue(1'b0, 32'h0001_0000);
    issue(1'b1, 32'hFFFF_8000);
    issue(1'b1, 32'h0000_0001);
    issue(1'b0, 32'h0000_0000);
    issue(1'b1, 32'hFFFF_FFFF);
    issue(1'b1, 32'h0000_0000);
    issue(1'b0, 32'h8000_0001);
    issue(1'b0, 32'h0000_0001);
    issue(1'b1, 32'h4000_0000);
    issue(1'b1, 32'hBFFF_FFFF);
    issue(1'b0, 32'h0800_0000);

    held_start(1'b0, 32'h0000_0F00, 1'b1, 32'hFFF0_0000);
    held_start(1'b0, 32'h0000_0000, 1'b0, 32'h8000_0000);

    // Abandon a long unsigned normalization partway through.
    wait_idle();
    start = 1'b1; mode = 1'b0; value_in = 32'h0000_0001;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    repeat (4) @(negedge clock);
    check("mid_busy", {31'h0, busy}, 32'h1);
    reset_n = 1'b0;
    @(posedge clock);
    @(negedge clock);
    hold_valid = 1'b0;
    check("mrst_result", result, 32'h0);
    check("mrst_count", {26'h0, count}, 32'h0);
    check("mrst_zero", {31'h0, zero}, 32'h0);
    check("mrst_busy", {31'h0, busy}, 32'h0);
    check("mrst_done", {31'h0, done}, 32'h0);
    reset_n = 1'b1;
    issue(1'b0, 32'h0001_0000);

    for (int i = 0; i < 40; i++) begin
      m = 1'($urandom_range(0, 1));
      sel = $urandom_range(0, 9);
      if (sel == 0) v = 32'h0;
      else if (sel == 1) v = 32'hFFFF_FFFF;
      else begin
        v = $urandom >> $urandom_range(0, 31);
        if ($urandom_range(0, 1) == 1) v = ~v;
      end
      issue(m, v);
    end

    g = 0;
    while (sb.size() > 0 && g < 500) begin
      @(negedge clock);
      g++;
    end
    if (sb.size() > 0) begin
      total++; bad++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
    end
    repeat (3) @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
